// File: rtl/buffer_slot_pkg.sv
// Shared types and helpers for the buffer slot fill path: FSM state encoding,
// features-per-line and pad-count arithmetic.
package buffer_slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FREE = 2'd1,
    ST_FILL      = 2'd2
  } state_e;

  function automatic int unsigned calc_fpl(input int unsigned write_width,
                                           input int unsigned read_width);
    return write_width / read_width;
  endfunction

  // Lane counter width; never zero even when a line holds a single feature.
  function automatic int unsigned calc_lane_bits(input int unsigned fpl);
    if (fpl > 32'd1) begin
      return $clog2(fpl);
    end else begin
      return 32'd1;
    end
  endfunction

  function automatic int unsigned calc_pad(input int unsigned count,
                                           input int unsigned fpl);
    int unsigned rem;
    rem = count % fpl;
    if (rem == 32'd0) begin
      return 32'd0;
    end else begin
      return fpl - rem;
    end
  endfunction

endpackage

// File: rtl/feature_line_packer.sv
// Packs narrow features into a wide line; flushes on a full line or on the last
// feature of a request, with untouched lanes left at the pad value.
module feature_line_packer
  import buffer_slot_pkg::*;
#(
  parameter int unsigned              WRITE_WIDTH = 64,
  parameter int unsigned              READ_WIDTH  = 32,
  parameter logic [READ_WIDTH-1:0]    PAD_VALUE   = '0
) (
  input  logic                   core_clk,
  input  logic                   resetn,
  input  logic                   i_beat,
  input  logic                   i_last,
  input  logic [READ_WIDTH-1:0]  i_data,
  output logic                   o_line_done,
  output logic                   o_write_enable,
  output logic [WRITE_WIDTH-1:0] o_write_data
);

  localparam int unsigned FPL = calc_fpl(WRITE_WIDTH, READ_WIDTH);
  localparam int unsigned LW  = calc_lane_bits(FPL);
  localparam logic [LW-1:0] LAST_LANE = LW'(FPL - 1);
  localparam logic [WRITE_WIDTH-1:0] PAD_LINE = {FPL{PAD_VALUE}};

  logic [LW-1:0]          r_lane_cnt;
  logic [WRITE_WIDTH-1:0] r_acc;
  logic [WRITE_WIDTH-1:0] r_write_data;
  logic                   r_write_enable;
  logic [WRITE_WIDTH-1:0] w_merged;
  logic                   w_line_done;

  // Drop the incoming feature into the lane selected by the lane counter.
  always_comb begin
    w_merged = r_acc;
    for (int i = 0; i < int'(FPL); i++) begin
      if (LW'(i) == r_lane_cnt) begin
        w_merged[i*READ_WIDTH +: READ_WIDTH] = i_data;
      end else begin
        w_merged[i*READ_WIDTH +: READ_WIDTH] = r_acc[i*READ_WIDTH +: READ_WIDTH];
      end
    end
    w_line_done = i_beat && ((r_lane_cnt == LAST_LANE) || i_last);
  end

  // The accumulator restarts from an all-pad line, so a short flush is padded for free.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_lane_cnt     <= '0;
      r_acc          <= PAD_LINE;
      r_write_data   <= '0;
      r_write_enable <= 1'b0;
    end else begin
      r_write_enable <= w_line_done;
      if (w_line_done) begin
        r_write_data <= w_merged;
        r_acc        <= PAD_LINE;
        r_lane_cnt   <= '0;
      end else if (i_beat) begin
        r_acc        <= w_merged;
        r_lane_cnt   <= r_lane_cnt + LW'(1);
      end
    end
  end

  assign o_line_done    = w_line_done;
  assign o_write_enable = r_write_enable;
  assign o_write_data   = r_write_data;

endmodule

// File: rtl/buffer_slot_writer.sv
// Fill-side controller for a hybrid buffer slot: request FSM, line pointer and
// pad reporting. Optional stall counter enabled by BUFFER_SLOT_WRITER_PERF_EN.
module buffer_slot_writer
  import buffer_slot_pkg::*;
#(
  parameter int unsigned           WRITE_WIDTH = 64,
  parameter int unsigned           WRITE_DEPTH = 512,
  parameter int unsigned           READ_WIDTH  = 32,
  parameter int unsigned           READ_DEPTH  = 1024,
  parameter logic [READ_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                                        core_clk,
  input  logic                                        resetn,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [$clog2(READ_DEPTH):0]                 req_feature_count,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [READ_WIDTH-1:0]                       in_data,
  input  logic                                        slot_free,
  output logic                                        write_enable,
  output logic [$clog2(WRITE_DEPTH)-1:0]              write_address,
  output logic [WRITE_WIDTH-1:0]                      write_data,
  output logic                                        fill_done,
  output logic [$clog2(WRITE_WIDTH/READ_WIDTH):0]     fill_pad_count,
  output logic [31:0]                                 stall_cycles
);

  localparam int unsigned FPL = calc_fpl(WRITE_WIDTH, READ_WIDTH);
  localparam int unsigned CW  = $clog2(READ_DEPTH) + 1;
  localparam int unsigned AW  = $clog2(WRITE_DEPTH);
  localparam int unsigned PW  = $clog2(FPL) + 1;

  state_e          r_state;
  state_e          w_state_next;
  logic [CW-1:0]   r_remaining;
  logic [AW-1:0]   r_line_ptr;
  logic [AW-1:0]   r_write_address;
  logic            r_fill_done;
  logic [PW-1:0]   r_fill_pad_count;
  logic [PW-1:0]   r_pad_pending;
  logic [CW-1:0]   w_clamped;
  logic            w_accept;
  logic            w_zero;
  logic            w_beat;
  logic            w_last;
  logic            w_line_done;

  // Request/beat qualifiers and count clamping.
  always_comb begin
    if (req_feature_count > CW'(READ_DEPTH)) begin
      w_clamped = CW'(READ_DEPTH);
    end else begin
      w_clamped = req_feature_count;
    end
    w_accept = req_valid && (r_state == ST_IDLE);
    w_zero   = (w_clamped == CW'(0));
    w_beat   = in_valid && (r_state == ST_FILL);
    w_last   = w_beat && (r_remaining == CW'(1));
  end

  // State register.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a zero-count request completes without leaving IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_zero) begin
          w_state_next = ST_WAIT_FREE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_FREE: begin
        if (slot_free) begin
          w_state_next = ST_FILL;
        end else begin
          w_state_next = ST_WAIT_FREE;
        end
      end
      ST_FILL: begin
        if (w_last) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_FILL;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    req_ready = 1'b0;
    in_ready  = 1'b0;
    case (r_state)
      ST_IDLE:      req_ready = 1'b1;
      ST_WAIT_FREE: req_ready = 1'b0;
      ST_FILL:      in_ready  = 1'b1;
      default: begin
        req_ready = 1'b0;
        in_ready  = 1'b0;
      end
    endcase
  end

  // Request bookkeeping, line pointer and completion reporting. The line
  // pointer tracks the slot's wrapping read pointer, so it survives requests.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_remaining      <= '0;
      r_pad_pending    <= '0;
      r_line_ptr       <= '0;
      r_write_address  <= '0;
      r_fill_done      <= 1'b0;
      r_fill_pad_count <= '0;
    end else begin
      r_fill_done <= (w_accept && w_zero) || w_last;
      if (w_accept) begin
        r_remaining   <= w_clamped;
        r_pad_pending <= PW'(calc_pad(32'(w_clamped), FPL));
      end else if (w_beat) begin
        r_remaining   <= r_remaining - CW'(1);
      end
      if (w_accept && w_zero) begin
        r_fill_pad_count <= '0;
      end else if (w_last) begin
        r_fill_pad_count <= r_pad_pending;
      end
      if (w_line_done) begin
        r_write_address <= r_line_ptr;
        if (r_line_ptr == AW'(WRITE_DEPTH - 1)) begin
          r_line_ptr <= '0;
        end else begin
          r_line_ptr <= r_line_ptr + AW'(1);
        end
      end
    end
  end

  feature_line_packer #(
    .WRITE_WIDTH (WRITE_WIDTH),
    .READ_WIDTH  (READ_WIDTH),
    .PAD_VALUE   (PAD_VALUE)
  ) u_packer (
    .core_clk       (core_clk),
    .resetn         (resetn),
    .i_beat         (w_beat),
    .i_last         (w_last),
    .i_data         (in_data),
    .o_line_done    (w_line_done),
    .o_write_enable (write_enable),
    .o_write_data   (write_data)
  );

  assign write_address  = r_write_address;
  assign fill_done      = r_fill_done;
  assign fill_pad_count = r_fill_pad_count;

`ifdef BUFFER_SLOT_WRITER_PERF_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of FILL cycles starved of input.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= 32'd0;
    end else if (w_accept) begin
      r_stall_cycles <= 32'd0;
    end else if ((r_state == ST_FILL) && !in_valid && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_buffer_slot_writer.sv
// Scoreboard bench for buffer_slot_writer (default parameters, two features per line).
module tb_buffer_slot_writer;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [63:0] data;
    logic        done;
    logic [1:0]  pad;
  } exp_t;

  logic        core_clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_feature_count = 11'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        slot_free = 1'b1;
  logic        write_enable;
  logic [8:0]  write_address;
  logic [63:0] write_data;
  logic        fill_done;
  logic [1:0]  fill_pad_count;
  logic [31:0] stall_cycles;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_ptr = 0;

  buffer_slot_writer dut (
    .core_clk          (core_clk),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_feature_count (req_feature_count),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .slot_free         (slot_free),
    .write_enable      (write_enable),
    .write_address     (write_address),
    .write_data        (write_data),
    .fill_done         (fill_done),
    .fill_pad_count    (fill_pad_count),
    .stall_cycles      (stall_cycles)
  );

  always #5 core_clk = ~core_clk;

  // Monitor: every write or completion pulse must match the oldest expectation.
  always @(negedge core_clk) begin
    if (resetn && (write_enable || fill_done)) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output we=%0b addr=%0d data=%h done=%0b", write_enable,
                 write_address, write_data, fill_done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (write_enable !== e.we || fill_done !== e.done ||
            (e.we && (write_address !== e.addr || write_data !== e.data)) ||
            (e.done && fill_pad_count !== e.pad)) begin
          n_err++;
          $display("FAIL write_check got we=%0b addr=%0d data=%h done=%0b pad=%0d want we=%0b addr=%0d data=%h done=%0b pad=%0d",
                   write_enable, write_address, write_data, fill_done, fill_pad_count,
                   e.we, e.addr, e.data, e.done, e.pad);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input int addr, input logic [63:0] data,
                      input logic done, input logic [1:0] pad);
    exp_t e;
    e.we = we; e.addr = addr[8:0]; e.data = data; e.done = done; e.pad = pad;
    sb.push_back(e);
  endtask

  task automatic do_req(input int cnt);
    @(negedge core_clk);
    req_valid = 1'b1;
    req_feature_count = cnt[10:0];
    @(negedge core_clk);
    req_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      int budget = 0;
      while (!in_ready && budget < 50) begin
        @(negedge core_clk);
        budget++;
      end
      if (!in_ready) begin
        n_vec++; n_err++;
        $display("FAIL in_ready_timeout got 0 want 1");
      end
      in_valid = 1'b1;
      in_data = base + 32'(k);
      @(negedge core_clk);
    end
    in_valid = 1'b0;
  endtask

  // Generic fill: model packing (lane0 = even beat), pad lanes zero, pointer wrap.
  task automatic run_fill(input int cnt, input logic [31:0] base);
    int nf;
    int nl;
    nf = (cnt > 1024) ? 1024 : cnt;
    nl = (nf + 1) / 2;
    for (int j = 0; j < nl; j++) begin
      logic [31:0] lo;
      logic [31:0] hi;
      lo = base + 32'(2*j);
      hi = (2*j + 1 < nf) ? base + 32'(2*j + 1) : 32'd0;
      push(1'b1, exp_ptr, {hi, lo}, (j == nl - 1), ((nf % 2) != 0) ? 2'd1 : 2'd0);
      exp_ptr = (exp_ptr + 1) % 512;
    end
    do_req(cnt);
    send_beats(nf, base);
  endtask

  task automatic drain;
    int budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      @(negedge core_clk);
      budget++;
    end
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    repeat (3) @(negedge core_clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_outputs", {write_enable, fill_done, in_ready, write_address, fill_pad_count,
                          stall_cycles != 32'd0}, 64'd0);
    resetn = 1'b1;

    // Aligned fill: A,B,C,D -> {B,A}@0, {D,C}@1
    push(1'b1, 0, {32'hBBBB_0002, 32'hAAAA_0001}, 1'b0, 2'd0);
    push(1'b1, 1, {32'hDDDD_0004, 32'hCCCC_0003}, 1'b1, 2'd0);
    do_req(4);
    chk("in_ready_T1", 64'(in_ready), 64'd0);
    @(negedge core_clk);
    chk("in_ready_T2", 64'(in_ready), 64'd1);
    chk("req_ready_fill", 64'(req_ready), 64'd0);
    foreach (sb[i]) begin end
    in_valid = 1'b1; in_data = 32'hAAAA_0001; @(negedge core_clk);
    in_data = 32'hBBBB_0002; @(negedge core_clk);
    in_data = 32'hCCCC_0003; @(negedge core_clk);
    in_data = 32'hDDDD_0004; @(negedge core_clk);
    in_valid = 1'b0;
    chk("req_ready_after_done", 64'(req_ready), 64'd1);
    exp_ptr = 2;
    drain();

    // Partial fill: 3 beats -> {B,A}@2, {PAD,C}@3 pad 1; then count 2 at addr 4
    push(1'b1, 2, {32'h0000_00B1, 32'h0000_00A1}, 1'b0, 2'd0);
    push(1'b1, 3, {32'h0000_0000, 32'h0000_00C1}, 1'b1, 2'd1);
    do_req(3);
    send_beats(1, 32'h0000_00A1);
    send_beats(1, 32'h0000_00B1);
    send_beats(1, 32'h0000_00C1);
    exp_ptr = 4;
    drain();
    chk("pad_held", 64'(fill_pad_count), 64'd1);
    run_fill(2, 32'h1000_0000);
    drain();

    // Count zero: fill_done at T+1 only
    push(1'b0, 0, 64'd0, 1'b1, 2'd0);
    do_req(0);
    chk("zero_write_enable", 64'(write_enable), 64'd0);
    drain();

    // Gating: slot busy for 10 cycles, in_valid outside FILL ignored
    slot_free = 1'b0;
    push(1'b1, exp_ptr, {32'h2000_0001, 32'h2000_0000}, 1'b1, 2'd0);
    exp_ptr++;
    do_req(2);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    bad = 0;
    repeat (10) begin
      @(negedge core_clk);
      if (in_ready !== 1'b0) bad++;
    end
    chk("gated_in_ready", 64'(bad), 64'd0);
    slot_free = 1'b1;
    @(negedge core_clk);
    chk("in_ready_after_free", 64'(in_ready), 64'd1);
    send_beats(2, 32'h2000_0000);
    drain();

    // Clamp 2000 -> 1024 features, 512 writes
    run_fill(2000, 32'h3000_0000);
    drain();

    // Wrap: advance pointer to 511, then 4 features -> addr 511 then 0
    run_fill(2 * (511 - exp_ptr), 32'h4000_0000);
    drain();
    chk("wrap_pre_ptr", 64'(exp_ptr), 64'd511);
    run_fill(4, 32'h5000_0000);
    drain();

    // Stall counter: 5 FILL cycles without input
    push(1'b1, exp_ptr, {32'h6000_0001, 32'h6000_0000}, 1'b1, 2'd0);
    exp_ptr++;
    do_req(2);
    @(negedge core_clk);
    repeat (5) @(negedge core_clk);
    send_beats(2, 32'h6000_0000);
    drain();
`ifdef BUFFER_SLOT_WRITER_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'd5);
`else
    chk("stall_cycles", 64'(stall_cycles), 64'd0);
`endif

    // Reset mid-fill after one beat
    do_req(4);
    send_beats(1, 32'h7000_0000);
    resetn = 1'b0;
    #1;
    chk("midreset_req_ready", 64'(req_ready), 64'd1);
    chk("midreset_outputs", {write_enable, fill_done, in_ready, write_address, fill_pad_count,
                             stall_cycles != 32'd0}, 64'd0);
    chk("midreset_data", write_data, 64'd0);
    @(negedge core_clk);
    resetn = 1'b1;
    repeat (4) @(negedge core_clk);
    exp_ptr = 0;
    run_fill(2, 32'h8000_0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/buffer_slot_writer.md
Name: buffer_slot_writer

Overview:
- Fill-side controller for a hybrid buffer slot.
- Accepts a fetch request (feature count) plus a narrow feature stream, packs FEATURES_PER_LINE features per wide line and drives the slot's write port (write_enable / write_address / write_data).
- Waits for the slot to report free before filling.
- Reports padding so the pop-side consumer can discard pad features and keep its read pointer aligned.

Parameters:
- WRITE_WIDTH, 64, slot write-port width in bits.
- WRITE_DEPTH, 512, slot lines; line pointer wraps at this value.
- READ_WIDTH, 32, feature width; input stream width.
- READ_DEPTH, 1024, slot capacity in features; must equal WRITE_DEPTH*WRITE_WIDTH/READ_WIDTH.
- PAD_VALUE, 0, READ_WIDTH-bit value written into unused lanes of a partial final line.

Ports:
- core_clk  in  1  clock; single clock domain.
- resetn  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  fill request valid.
- req_ready  out  1  high only in IDLE.
- req_feature_count  in  $clog2(READ_DEPTH)+1  features to fill; values above READ_DEPTH are clamped to READ_DEPTH.
- in_valid  in  1  feature beat valid.
- in_ready  out  1  high only in FILL.
- in_data  in  READ_WIDTH  feature beat.
- slot_free  in  1  slot empty indication from the buffer slot.
- write_enable  out  1  one-cycle line write strobe.
- write_address  out  $clog2(WRITE_DEPTH)  line address.
- write_data  out  WRITE_WIDTH  packed line; first-accepted feature in bits [READ_WIDTH-1:0].
- fill_done  out  1  one-cycle pulse at request completion.
- fill_pad_count  out  $clog2(WRITE_WIDTH/READ_WIDTH)+1  pad features in last line; held until next fill_done.
- stall_cycles  out  32  FILL cycles with in_valid low (see Optional Feature).

Behaviour:
- FPL = WRITE_WIDTH/READ_WIDTH, power of two, ≥1.
- Reset values: all outputs 0, except req_ready = 1 (IDLE). Line pointer = 0, lane counter = 0.
- Reset mid-fill: abandons the fill, no further writes, no fill_done.
- States:
  - IDLE: req_ready = 1. On req_valid at cycle T, latch the clamped count. Count 0 -> fill_done at T+1, pad 0, stay IDLE. Otherwise go to WAIT_FREE.
  - WAIT_FREE: move to FILL the cycle after slot_free is seen high. With slot_free already high, in_ready first rises at T+2.
  - FILL: in_ready = 1. Each accepted beat goes into lane[lane_cnt], lane_cnt++, remaining--.
- Line completion: a line completes on the beat that fills lane FPL-1, or on the beat that takes remaining to 0.
  - Completing beat at cycle t -> write_enable = 1 at t+1, with registered write_address = line_ptr and write_data = packed lanes.
  - Unused lanes are filled with PAD_VALUE.
  - line_ptr increments after the write and wraps WRITE_DEPTH-1 -> 0.
- Final line: fill_done = 1 coincident with the final write_enable. fill_pad_count = FPL - (count mod FPL), or 0 if the count divides evenly. State returns to IDLE at t+1, so req_ready = 1 at t+1.
- line_ptr is never reset between requests; it persists to track the slot's continuously wrapping read pointer. Pad features must be popped by the consumer.
- No write-side backpressure: every completing beat produces exactly one write.
- slot_free is sampled only in WAIT_FREE; it is ignored during FILL.
- in_valid outside FILL is ignored and no beat is consumed.

Optional Feature:
- Macro: BUFFER_SLOT_WRITER_PERF_EN.
- Defined: stall_cycles counts cycles in FILL with in_valid = 0. It saturates at 2^32-1 and clears on req acceptance.
- Undefined: stall_cycles is tied to 0 and no counter logic is instantiated.
- Port list is identical in both builds.

Decomposition:
- Shared package buffer_slot_pkg holds:
  - state enum (IDLE, WAIT_FREE, FILL);
  - FPL constant function;
  - pad-count computation function.
- One natural sub-module, feature_line_packer: lane register, lane counter, flush-with-pad. The FSM and pointers stay in the top level.

Test Plan (defaults, FPL = 2):
- Aligned fill: slot_free = 1, req count 4, beats A,B,C,D back-to-back -> two writes, addr 0 data {B,A} and addr 1 data {D,C}. fill_done on the second write, pad 0.
- Partial fill: req count 3, beats A,B,C -> writes {B,A}@0 and {PAD,C}@1, pad 1. A following count-2 request writes at addr 2.
- Wrap: preload line_ptr to 511 via prior fills, then req count 4 -> writes at addr 511 then 0.
- Gating: req while slot_free = 0 for 10 cycles -> in_ready stays 0 and no writes. slot_free rises -> in_ready rises next cycle.
- Edge cases:
  - req count 0 -> fill_done at T+1, no write_enable.
  - req count 2000 -> clamped to 1024, 512 writes.
- Reset mid-fill after 1 beat -> all outputs 0, req_ready = 1, no fill_done. Next fill starts at addr 0.
- With BUFFER_SLOT_WRITER_PERF_EN, 5 idle FILL cycles -> stall_cycles = 5. Without the macro -> stall_cycles = 0.
